// File: rtl/note_disp_pkg.sv
// Shared types and seg7 codes for the note history display.
package note_disp_pkg;

    localparam int unsigned NOTE_W = 4;
    localparam int unsigned SEG_W  = 4;

    localparam logic [NOTE_W-1:0] NOTE_C  = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_CS = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D  = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_DS = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_E  = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_F  = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_FS = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_G  = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_GS = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_A  = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_AS = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_B  = 4'd11;

    localparam logic [SEG_W-1:0] SEG_C     = 4'hC;
    localparam logic [SEG_W-1:0] SEG_D     = 4'hD;
    localparam logic [SEG_W-1:0] SEG_E     = 4'hE;
    localparam logic [SEG_W-1:0] SEG_F     = 4'hF;
    localparam logic [SEG_W-1:0] SEG_G     = 4'h1;
    localparam logic [SEG_W-1:0] SEG_A     = 4'hA;
    localparam logic [SEG_W-1:0] SEG_B     = 4'hB;
    localparam logic [SEG_W-1:0] SEG_SHARP = 4'h0;
    localparam logic [SEG_W-1:0] SEG_OFF   = 4'h8;

    typedef struct packed {
        logic             valid;
        logic             rest;
        logic [SEG_W-1:0] letter;
        logic             sharp;
    } slot_t;

    typedef struct packed {
        logic [SEG_W-1:0] letter;
        logic [SEG_W-1:0] sharp;
        logic             letter_en;
        logic             sharp_en;
    } slot_disp_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_e;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rest: 1'b0, letter: SEG_OFF, sharp: 1'b0};

    // Digit pair for one slot; rests and empty slots are blanked with the off code.
    function automatic slot_disp_t slot_disp(input slot_t s);
        slot_disp_t d;
        d.letter    = SEG_OFF;
        d.sharp     = SEG_OFF;
        d.letter_en = 1'b0;
        d.sharp_en  = 1'b0;
        if (s.valid && !s.rest) begin
            d.letter    = s.letter;
            d.sharp     = SEG_SHARP;
            d.letter_en = 1'b1;
            d.sharp_en  = s.sharp;
        end
        return d;
    endfunction

endpackage

// File: rtl/note_encoder.sv
// Maps a chromatic note index to a display slot (letter code + sharp flag).
module note_encoder
    import note_disp_pkg::*;
(
    input  logic [NOTE_W-1:0] note_idx_i,
    output slot_t             slot_o
);

    always_comb begin
        slot_o = '{valid: 1'b1, rest: 1'b0, letter: SEG_OFF, sharp: 1'b0};
        case (note_idx_i)
            NOTE_C:  slot_o.letter = SEG_C;
            NOTE_CS: begin slot_o.letter = SEG_C; slot_o.sharp = 1'b1; end
            NOTE_D:  slot_o.letter = SEG_D;
            NOTE_DS: begin slot_o.letter = SEG_D; slot_o.sharp = 1'b1; end
            NOTE_E:  slot_o.letter = SEG_E;
            NOTE_F:  slot_o.letter = SEG_F;
            NOTE_FS: begin slot_o.letter = SEG_F; slot_o.sharp = 1'b1; end
            NOTE_G:  slot_o.letter = SEG_G;
            NOTE_GS: begin slot_o.letter = SEG_G; slot_o.sharp = 1'b1; end
            NOTE_A:  slot_o.letter = SEG_A;
            NOTE_AS: begin slot_o.letter = SEG_A; slot_o.sharp = 1'b1; end
            NOTE_B:  slot_o.letter = SEG_B;
            default: slot_o.rest = 1'b1;
        endcase
    end

endmodule

// File: rtl/note_display_ctrl.sv
// Three-deep note history on six seg7 digits with a minimum dwell per note.
// Optional newest-note blink enabled by defining NOTE_DISP_BLINK_EN.
module note_display_ctrl
    import note_disp_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 5000000,
    parameter int unsigned BLINK_HALF   = 12500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              note_valid,
    output logic              note_ready,
    input  logic [NOTE_W-1:0] note_idx,
    input  logic              clear,
    output logic [23:0]       hex_codes,
    output logic [5:0]        digit_en
);

    localparam int unsigned DCW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        $error("DWELL_CYCLES must be at least 1");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("BLINK_HALF must be at least 1");
    end

    state_e           state_q;
    logic [DCW-1:0]   dwell_q;
    slot_t [2:0]      slots_q, slots_d;
    slot_t            enc_slot;
    logic             accept;
    logic             slot0_on;
    slot_disp_t       d0, d1, d2;
    logic [23:0]      hex_d, hex_q;
    logic [5:0]       en_d, en_q;

    note_encoder u_enc (
        .note_idx_i (note_idx),
        .slot_o     (enc_slot)
    );

    assign note_ready = (state_q == ST_IDLE) & ~clear;
    assign accept     = note_valid & note_ready;

    // Dwell FSM: clear wins over everything, including an in-progress dwell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
        end else if (clear) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_DWELL;
                        dwell_q <= DCW'(DWELL_CYCLES - 1);
                    end
                end
                ST_DWELL: begin
                    if (dwell_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        dwell_q <= dwell_q - DCW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        slots_d = slots_q;
        if (clear) begin
            slots_d = {SLOT_EMPTY, SLOT_EMPTY, SLOT_EMPTY};
        end else if (accept) begin
            slots_d = {slots_q[1], slots_q[0], enc_slot};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots_q <= {SLOT_EMPTY, SLOT_EMPTY, SLOT_EMPTY};
        end else begin
            slots_q <= slots_d;
        end
    end

`ifdef NOTE_DISP_BLINK_EN
    localparam int unsigned BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BCW-1:0] blink_q, blink_d;
    logic           phase_q, phase_d;

    // Free-running half-period counter; a new note restarts in the on phase.
    always_comb begin
        blink_d = blink_q + BCW'(1);
        phase_d = phase_q;
        if (accept) begin
            blink_d = '0;
            phase_d = 1'b1;
        end else if (blink_q == BCW'(BLINK_HALF - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q <= '0;
            phase_q <= 1'b1;
        end else begin
            blink_q <= blink_d;
            phase_q <= phase_d;
        end
    end

    assign slot0_on = phase_d;
`else
    assign slot0_on = 1'b1;
`endif

    // Outputs are built from next-state slots so they update on the transfer edge.
    always_comb begin
        d0    = slot_disp(slots_d[0]);
        d1    = slot_disp(slots_d[1]);
        d2    = slot_disp(slots_d[2]);
        hex_d = {d2.letter, d2.sharp, d1.letter, d1.sharp, d0.letter, d0.sharp};
        en_d  = {d2.letter_en, d2.sharp_en, d1.letter_en, d1.sharp_en,
                 d0.letter_en & slot0_on, d0.sharp_en & slot0_on};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q <= {6{SEG_OFF}};
            en_q  <= '0;
        end else begin
            hex_q <= hex_d;
            en_q  <= en_d;
        end
    end

    assign hex_codes = hex_q;
    assign digit_en  = en_q;

endmodule

// File: tb/tb_note_display_ctrl.sv
// Self-checking bench for note_display_ctrl (DWELL_CYCLES=4, BLINK_HALF=3).
module tb_note_display_ctrl;

    localparam int unsigned DWELL = 4;
    localparam int unsigned BLINK = 3;

    logic        clk;
    logic        reset;
    logic        note_valid;
    logic        note_ready;
    logic [3:0]  note_idx;
    logic        clear;
    logic [23:0] hex_codes;
    logic [5:0]  digit_en;

    typedef struct {
        logic        clr;
        logic        vld;
        logic [3:0]  idx;
        logic        rdy;
        logic [23:0] hex;
        logic [5:0]  en;
    } vec_t;

    typedef struct {
        logic [23:0] hex;
        logic [5:0]  en;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
`ifdef NOTE_DISP_BLINK_EN
    int   since = 0;
`endif

    note_display_ctrl #(
        .DWELL_CYCLES (DWELL),
        .BLINK_HALF   (BLINK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_idx   (note_idx),
        .clear      (clear),
        .hex_codes  (hex_codes),
        .digit_en   (digit_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic v, input logic [3:0] i,
                                input logic r, input logic [23:0] h, input logic [5:0] e);
        vec_t t;
        t.clr = c; t.vld = v; t.idx = i; t.rdy = r; t.hex = h; t.en = e;
        return t;
    endfunction

    // One clock: drive, check ready before the edge, check outputs just after it.
    task automatic step(input vec_t t);
        exp_t e;
        exp_t got;
        clear      = t.clr;
        note_valid = t.vld;
        note_idx   = t.idx;
        #1;
        check("note_ready", 32'(note_ready), 32'(t.rdy));
        e.hex = t.hex;
        e.en  = t.en;
`ifdef NOTE_DISP_BLINK_EN
        if (t.rdy && t.vld && !t.clr) since = 0;
        else since++;
        if (((since / BLINK) % 2) != 0) e.en[1:0] = 2'b00;
`endif
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("hex_codes", 32'(hex_codes), 32'(got.hex));
        check("digit_en", 32'(digit_en), 32'(got.en));
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; note_valid = 1'b0; note_idx = 4'd0;
        #2 reset = 1'b1;
        #1;
        check("rst_hex", 32'(hex_codes), 32'h888888);
        check("rst_en", 32'(digit_en), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready", 32'(note_ready), 32'h1);
        @(posedge clk);
        #1;

        vecs.push_back(mk(0, 0, 4'd0, 1, 24'h888888, 6'h00));
        vecs.push_back(mk(0, 1, 4'd1, 1, 24'h8888C0, 6'h03));
        repeat (4) vecs.push_back(mk(0, 1, 4'd9, 0, 24'h8888C0, 6'h03));
        vecs.push_back(mk(0, 1, 4'd9, 1, 24'h88C0A0, 6'h0E));
        repeat (4) vecs.push_back(mk(0, 1, 4'd12, 0, 24'h88C0A0, 6'h0E));
        vecs.push_back(mk(0, 1, 4'd12, 1, 24'hC0A088, 6'h38));
        repeat (4) vecs.push_back(mk(0, 1, 4'd7, 0, 24'hC0A088, 6'h38));
        vecs.push_back(mk(0, 1, 4'd7, 1, 24'hA08810, 6'h22));
        repeat (4) vecs.push_back(mk(0, 1, 4'd4, 0, 24'hA08810, 6'h22));
        vecs.push_back(mk(0, 1, 4'd4, 1, 24'h8810E0, 6'h0A));
        vecs.push_back(mk(1, 1, 4'd3, 0, 24'h888888, 6'h00));
        vecs.push_back(mk(1, 1, 4'd3, 0, 24'h888888, 6'h00));
        vecs.push_back(mk(0, 1, 4'd3, 1, 24'h8888D0, 6'h03));
        vecs.push_back(mk(1, 1, 4'd0, 0, 24'h888888, 6'h00));
        vecs.push_back(mk(0, 1, 4'd0, 1, 24'h8888C0, 6'h02));
        repeat (4) vecs.push_back(mk(0, 0, 4'd0, 0, 24'h8888C0, 6'h02));
        vecs.push_back(mk(1, 1, 4'd5, 0, 24'h888888, 6'h00));
        vecs.push_back(mk(0, 1, 4'd5, 1, 24'h8888F0, 6'h02));
        vecs.push_back(mk(0, 0, 4'd0, 0, 24'h8888F0, 6'h02));

        foreach (vecs[i]) step(vecs[i]);

        // Dwell counter is now 2: asynchronous reset must abort immediately.
        #2 reset = 1'b1;
        #1;
        check("async_rst_hex", 32'(hex_codes), 32'h888888);
        check("async_rst_en", 32'(digit_en), 32'h0);
        @(posedge clk);
        #1;
        check("held_rst_hex", 32'(hex_codes), 32'h888888);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(note_ready), 32'h1);
        @(posedge clk);
        #1;
        check("post_rst_hex", 32'(hex_codes), 32'h888888);
        check("post_rst_en", 32'(digit_en), 32'h0);
`ifdef NOTE_DISP_BLINK_EN
        since = 0;
`endif
        step(mk(0, 1, 4'd11, 1, 24'h8888B0, 6'h02));
        step(mk(0, 0, 4'd0, 0, 24'h8888B0, 6'h02));
        step(mk(0, 1, 4'd2, 0, 24'h8888B0, 6'h02));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
